// File: rtl/button_conditioner.sv
// button_conditioner
// Multi-channel push-button conditioner. Each channel synchronises its raw
// button, filters bounce symmetrically on press and release, and reports a
// debounced level plus press, release, long-press and auto-repeat pulses.
// Channels share nothing but the clock and reset.

module button_conditioner #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int LONG_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 6250000,
    parameter int REPEAT_EN       = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] btn_down,
    output logic [CHANNELS-1:0] btn_held,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] long_pulse,
    output logic [CHANNELS-1:0] repeat_pulse
);

    // One counter serves every timed state, so it is sized for the largest limit.
    localparam int MAX_AB  = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
    localparam int MAX_ALL = (MAX_AB > REPEAT_CYCLES) ? MAX_AB : REPEAT_CYCLES;
    localparam int CW      = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
    localparam bit            REPEAT_ON = (REPEAT_EN != 0);

    typedef enum logic [2:0] {
        ST_UP,
        ST_PRESS_CHK,
        ST_DOWN,
        ST_HELD,
        ST_REL_CHK
    } state_t;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : gChan
        logic [SYNC_STAGES-1:0] syncQ;
        logic                   s;
        state_t                 stateQ, stateNext;
        logic [CW-1:0]          cntQ, cntNext;
        logic                   heldQ, heldNext;
        logic                   downQ, downNext;
        logic                   pressQ, pressNext;
        logic                   releaseQ, releaseNext;
        logic                   longQ, longNext;
        logic                   repeatQ, repeatNext;

        assign s = syncQ[SYNC_STAGES-1];

        // Shift the raw asynchronous button level through the synchroniser chain.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                syncQ <= '0;
            end else begin
                syncQ <= {syncQ[SYNC_STAGES-2:0], btn_in[ch]};
            end
        end

        // Hold FSM state, counter, long-press flag and the registered outputs.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stateQ   <= ST_UP;
                cntQ     <= '0;
                heldQ    <= 1'b0;
                downQ    <= 1'b0;
                pressQ   <= 1'b0;
                releaseQ <= 1'b0;
                longQ    <= 1'b0;
                repeatQ  <= 1'b0;
            end else begin
                stateQ   <= stateNext;
                cntQ     <= cntNext;
                heldQ    <= heldNext;
                downQ    <= downNext;
                pressQ   <= pressNext;
                releaseQ <= releaseNext;
                longQ    <= longNext;
                repeatQ  <= repeatNext;
            end
        end

        // Decide the next state; every state change restarts the counter.
        always_comb begin
            stateNext = stateQ;
            cntNext   = cntQ;
            heldNext  = heldQ;
            case (stateQ)
                ST_UP: begin
                    cntNext = '0;
                    if (s) begin
                        stateNext = ST_PRESS_CHK;
                    end
                end
                ST_PRESS_CHK: begin
                    if (!s) begin
                        stateNext = ST_UP;
                        cntNext   = '0;
                    end else if (cntQ == DB_LAST) begin
                        stateNext = ST_DOWN;
                        cntNext   = '0;
                    end else begin
                        cntNext = cntQ + CW'(1);
                    end
                end
                ST_DOWN: begin
                    if (!s) begin
                        stateNext = ST_REL_CHK;
                        cntNext   = '0;
                    end else if (cntQ == LONG_LAST) begin
                        stateNext = ST_HELD;
                        cntNext   = '0;
                        heldNext  = 1'b1;
                    end else begin
                        cntNext = cntQ + CW'(1);
                    end
                end
                ST_HELD: begin
                    if (!s) begin
                        stateNext = ST_REL_CHK;
                        cntNext   = '0;
                    end else if (cntQ == REP_LAST) begin
                        cntNext = '0;
                    end else begin
                        cntNext = cntQ + CW'(1);
                    end
                end
                ST_REL_CHK: begin
                    if (s) begin
                        stateNext = heldQ ? ST_HELD : ST_DOWN;
                        cntNext   = '0;
                    end else if (cntQ == DB_LAST) begin
                        stateNext = ST_UP;
                        cntNext   = '0;
                        heldNext  = 1'b0;
                    end else begin
                        cntNext = cntQ + CW'(1);
                    end
                end
                default: begin
                    stateNext = ST_UP;
                    cntNext   = '0;
                    heldNext  = 1'b0;
                end
            endcase
        end

        // Derive the next output values from the transition being taken.
        always_comb begin
            downNext    = (stateNext == ST_DOWN) || (stateNext == ST_HELD) ||
                          (stateNext == ST_REL_CHK);
            pressNext   = (stateQ == ST_PRESS_CHK) && (stateNext == ST_DOWN);
            releaseNext = (stateQ == ST_REL_CHK) && (stateNext == ST_UP);
            longNext    = (stateQ == ST_DOWN) && (stateNext == ST_HELD);
            repeatNext  = REPEAT_ON && (stateQ == ST_HELD) && s && (cntQ == REP_LAST);
        end

        assign btn_down[ch]      = downQ;
        assign btn_held[ch]      = heldQ;
        assign press_pulse[ch]   = pressQ;
        assign release_pulse[ch] = releaseQ;
        assign long_pulse[ch]    = longQ;
        assign repeat_pulse[ch]  = repeatQ;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Multi-channel, parametrised push-button conditioner: synchronises raw board buttons, rejects bounce in both directions, and produces level, edge-pulse, long-press and auto-repeat outputs per channel. It sits between the board button pins and the camera control logic, for example capture trigger and register-step buttons. It replaces single-channel, press-only debouncing with symmetric, glitch-rejecting filtering.

## Interface
- CHANNELS, 4: number of independent button channels (>=1)
- SYNC_STAGES, 2: synchroniser flops per channel (>=2)
- DEBOUNCE_CYCLES, 250000: consecutive stable samples required to accept a press or release (>=1; 10 ms at 25 MHz)
- LONG_CYCLES, 25000000: cycles in DOWN before a long press is declared (>=1)
- REPEAT_CYCLES, 6250000: auto-repeat period while long-held (>=1)
- REPEAT_EN, 1: 1 = generate repeat_pulse in HELD, 0 = never
- clk  input  1  system clock (25 MHz pixel/system clock)
- rst  input  1  asynchronous, active-high reset
- btn_in  input  CHANNELS  raw, asynchronous, active-high button levels
- btn_down  output  CHANNELS  debounced level
- btn_held  output  CHANNELS  high while a long press is in effect
- press_pulse  output  CHANNELS  one-cycle pulse on accepted press
- release_pulse  output  CHANNELS  one-cycle pulse on accepted release
- long_pulse  output  CHANNELS  one-cycle pulse when long press is declared
- repeat_pulse  output  CHANNELS  one-cycle pulse each repeat period in HELD

## Operation
- Per channel: SYNC_STAGES-flop synchroniser, giving signal s, then an FSM plus one counter. The counter is $clog2(max(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES)) bits wide and never exceeds its current limit minus one. A held flag records a long press.
- Channels are fully independent; simultaneous events on any channels are all reported in the same cycle.
- UP: btn_down=0. If s=1, go to PRESS_CHK with cnt=0.
- PRESS_CHK: If s=0, go to UP (glitch rejected, no pulse). If s=1 and cnt==DEBOUNCE_CYCLES-1, go to DOWN with cnt=0; btn_down<=1 and press_pulse<=1. Otherwise cnt++.
- DOWN: If s=0, go to REL_CHK with cnt=0. If s=1 and cnt==LONG_CYCLES-1, go to HELD with cnt=0; btn_held<=1, held<=1 and long_pulse<=1. Otherwise cnt++.
- HELD: If s=0, go to REL_CHK with cnt=0. Otherwise, if REPEAT_EN is set and cnt==REPEAT_CYCLES-1, repeat_pulse<=1 and cnt=0; else cnt++.
- REL_CHK: btn_down and btn_held hold their values. If s=1 (bounce), return to HELD if held is set, else DOWN, with cnt=0; the long-press timer restarts. If s=0 and cnt==DEBOUNCE_CYCLES-1, go to UP with cnt=0; btn_down<=0, btn_held<=0, held<=0 and release_pulse<=1. Otherwise cnt++.
- All pulses are registered, last exactly one cycle, and are 0 in every other cycle.

## Timing
- Reset: all outputs 0, synchroniser flops 0, FSM in UP, cnt=0 and held=0, applied immediately on rst. Reset during any state produces no pulses. First evaluation happens on the first clk edge after rst deasserts.
- Press latency: btn_in rises before edge E0 and stays high. btn_down and press_pulse are high after edge E0+SYNC_STAGES+DEBOUNCE_CYCLES.
- Release latency: same as press latency, measured from the falling edge of btn_in.
- long_pulse occurs LONG_CYCLES edges after the press_pulse edge. The first repeat_pulse occurs REPEAT_CYCLES edges after long_pulse, then repeats every REPEAT_CYCLES edges.
- Any s pulse shorter than DEBOUNCE_CYCLES samples in PRESS_CHK or REL_CHK leaves btn_down unchanged.

## Test plan
All scenarios use CHANNELS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=10, REPEAT_CYCLES=3, REPEAT_EN=1.
- Clean press on ch0, rising before edge 0 and held 8 cycles -> btn_down[0] and press_pulse[0] high after edge 6; press_pulse low after edge 7; ch1 stays 0.
- Bounce: ch0 high for 3 cycles, low 1, high 3, low -> no press_pulse, btn_down[0] never 1.
- Long hold on ch1 for 30 cycles after press acceptance at edge P -> long_pulse at P+10, repeat_pulse at P+13, P+16, P+19 and so on; btn_held[1]=1 from P+10.
- Release bounce: in DOWN, btn_in[0] low 2 cycles then high -> no release_pulse, btn_down[0] stays 1. A later clean low gives release_pulse 6 edges after the fall.
- Simultaneous press on both channels in the same cycle -> press_pulse=2'b11 in one cycle.
- Assert rst while ch0 is in HELD -> all outputs 0 immediately, no release_pulse; after deassertion with btn_in held, a fresh press is accepted 6 edges later.
